// File: rtl/key_seq_decoder.sv
// key_seq_decoder: serial unlock-key decoder with mode capture, fail counting and timed lockout.
module key_seq_decoder #(
   parameter int                 KEY_LEN     = 4,
   parameter logic [KEY_LEN-1:0] KEY         = 4'b1010,
   parameter int                 MODE_BITS   = 1,
   parameter int                 MAX_FAIL    = 3,
   parameter int                 LOCK_CYCLES = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 InputKey,
   input  logic                 ValidCmd,
   input  logic                 Clear,
   output logic                 Active,
   output logic [MODE_BITS-1:0] Mode,
   output logic                 Fail,
   output logic                 Locked
);
   localparam int BMAX = KEY_LEN > MODE_BITS ? KEY_LEN : MODE_BITS;
   localparam int BW   = $clog2(BMAX + 1);
   localparam int FW   = $clog2(MAX_FAIL + 1);
   localparam int LW   = $clog2(LOCK_CYCLES + 1);
   localparam logic [1:0] S_KEY = 2'd0, S_MODE = 2'd1, S_ACTIVE = 2'd2, S_LOCK = 2'd3;
   logic [1:0]           state;
   logic [BW-1:0]        bit_cnt;
   logic [FW-1:0]        fail_cnt, fail_inc;
   logic [LW-1:0]        lock_cnt;
   logic [KEY_LEN-1:0]   key_sr, key_nx;
   logic [MODE_BITS-1:0] mode_sr, mode_nx;
   logic                 key_last, mode_last;
   always_comb begin
      key_nx    = KEY_LEN'({key_sr, InputKey});
      mode_nx   = MODE_BITS'({mode_sr, InputKey});
      key_last  = bit_cnt == BW'(KEY_LEN - 1);
      mode_last = bit_cnt == BW'(MODE_BITS - 1);
      fail_inc  = fail_cnt + 1'b1;
   end
   // Fail is a one-cycle pulse: cleared every cycle unless a mismatch sets it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= S_KEY;
         bit_cnt  <= '0;
         fail_cnt <= '0;
         lock_cnt <= '0;
         key_sr   <= '0;
         mode_sr  <= '0;
         Active   <= 1'b0;
         Mode     <= '0;
         Fail     <= 1'b0;
         Locked   <= 1'b0;
      end else begin
         Fail <= 1'b0;
         case (state)
            S_KEY:
               if (Clear) begin
                  bit_cnt <= '0;
                  key_sr  <= '0;
               end else if (ValidCmd) begin
                  if (!key_last) begin
                     key_sr  <= key_nx;
                     bit_cnt <= bit_cnt + 1'b1;
                  end else begin
                     key_sr  <= '0;
                     bit_cnt <= '0;
                     if (key_nx == KEY) begin
                        fail_cnt <= '0;
                        state    <= S_MODE;
                     end else begin
                        Fail     <= 1'b1;
                        fail_cnt <= fail_inc;
                        if (fail_inc == FW'(MAX_FAIL)) begin
                           state    <= S_LOCK;
                           Locked   <= 1'b1;
                           lock_cnt <= LW'(LOCK_CYCLES);
                        end
                     end
                  end
               end
            S_MODE:
               if (Clear) begin
                  state   <= S_KEY;
                  bit_cnt <= '0;
                  mode_sr <= '0;
               end else if (ValidCmd) begin
                  if (mode_last) begin
                     state   <= S_ACTIVE;
                     Active  <= 1'b1;
                     Mode    <= mode_nx;
                     bit_cnt <= '0;
                     mode_sr <= '0;
                  end else begin
                     mode_sr <= mode_nx;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            S_ACTIVE:
               if (Clear) begin
                  state   <= S_KEY;
                  Active  <= 1'b0;
                  Mode    <= '0;
                  bit_cnt <= '0;
               end
            default:
               if (lock_cnt == LW'(1)) begin
                  state    <= S_KEY;
                  Locked   <= 1'b0;
                  fail_cnt <= '0;
                  bit_cnt  <= '0;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt - 1'b1;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_key_seq_decoder.sv
// tb_key_seq_decoder: scoreboard bench; stimulus queues expected output changes, monitor checks them.
module tb_key_seq_decoder;
   logic Clk = 1'b0, Reset = 1'b1, InputKey = 1'b0, ValidCmd = 1'b0, Clear = 1'b0;
   logic Active, Fail, Locked;
   logic [0:0] Mode;
   typedef struct packed {
      logic [31:0] c;
      logic [3:0]  o;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int cyc = 0, n_checks = 0, n_fail = 0, lock_start;
   logic snap = 1'b0, done = 1'b0;
   logic [3:0] cur, prev = 4'b0000;

   key_seq_decoder dut (
      .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .Clear(Clear),
      .Active(Active), .Mode(Mode), .Fail(Fail), .Locked(Locked)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Output tuple is {Active, Mode, Fail, Locked}; each change must match the next queued entry and cycle.
   always @(negedge Clk) begin
      if (!Reset) begin
         cur = {Active, Mode, Fail, Locked};
         if (cur !== prev || snap) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change cycle %0d: got AMFL=%b, required unchanged %b", cyc, cur, prev);
            end else begin
               e = q.pop_front();
               if (e.o !== cur || e.c != cyc) begin
                  n_fail++;
                  $display("FAIL outputs cycle %0d: got AMFL=%b, required AMFL=%b at cycle %0d", cyc, cur, e.o, e.c);
               end
            end
            prev = cur;
         end
      end
      if (done) begin
         n_checks++;
         if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d pending, required 0", q.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   task automatic expect_at(input int c, input logic [3:0] o);
      exp_t x;
      x.c = c;
      x.o = o;
      q.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [7:0] bits, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         ValidCmd = 1'b1;
         InputKey = bits[i];
         @(posedge Clk);
         #1;
         ValidCmd = 1'b0;
         if (i > 0) idle(gap);
      end
   endtask

   task automatic clear_pulse();
      Clear = 1'b1;
      @(posedge Clk);
      #1;
      Clear = 1'b0;
   endtask

   task automatic snap_check(input logic [3:0] o);
      expect_at(cyc, o);
      snap = 1'b1;
      @(negedge Clk);
      #1;
      snap = 1'b0;
   endtask

   initial begin
      idle(3);
      Reset = 1'b0;
      snap_check(4'b0000);
      // back-to-back unlock, mode 1
      send(8'b10101, 5, 0);
      expect_at(cyc, 4'b1100);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      // gapped strobes, mode 0, then a lone bit after Clear must not unlock
      send(8'b10100, 5, 3);
      expect_at(cyc, 4'b1000);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      send(8'b1, 1, 0);
      idle(2);
      clear_pulse();
      // wrong key, then correct key clears the fail count
      send(8'b1011, 4, 0);
      expect_at(cyc, 4'b0010);
      expect_at(cyc + 1, 4'b0000);
      send(8'b10101, 5, 0);
      expect_at(cyc, 4'b1100);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         send(8'b0000, 4, 0);
         expect_at(cyc, 4'b0010);
         expect_at(cyc + 1, 4'b0000);
      end
      send(8'b10100, 5, 0);
      expect_at(cyc, 4'b1000);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      // lockout after three wrong keys
      for (int k = 0; k < 2; k++) begin
         send(8'b0000, 4, 0);
         expect_at(cyc, 4'b0010);
         expect_at(cyc + 1, 4'b0000);
      end
      send(8'b0000, 4, 0);
      lock_start = cyc;
      expect_at(lock_start, 4'b0011);
      expect_at(lock_start + 1, 4'b0001);
      expect_at(lock_start + 16, 4'b0000);
      send(8'b10101, 5, 0);
      while (cyc < lock_start + 16) idle(1);
      send(8'b10101, 5, 0);
      expect_at(cyc, 4'b1100);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      // reset mid-key discards partial bits
      send(8'b10, 2, 0);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      snap_check(4'b0000);
      send(8'b101, 3, 0);
      idle(2);
      clear_pulse();
      send(8'b10101, 5, 0);
      expect_at(cyc, 4'b1100);
      clear_pulse();
      expect_at(cyc, 4'b0000);
      // Clear wins over ValidCmd on the 4th key bit
      send(8'b101, 3, 0);
      ValidCmd = 1'b1;
      InputKey = 1'b0;
      Clear = 1'b1;
      @(posedge Clk);
      #1;
      ValidCmd = 1'b0;
      Clear = 1'b0;
      idle(2);
      send(8'b10101, 5, 0);
      expect_at(cyc, 4'b1100);
      idle(3);
      done = 1'b1;
      idle(5);
   end
endmodule
